// File: rtl/fifo_dram_param.sv
// Parametrised synchronous FIFO over a simple dual-port RAM with registered read port.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module fifo_dram_param #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned AF_TH  = 6,
    parameter int unsigned AE_TH  = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef FIFO_ERR_EN
    output logic              err_overflow,
    output logic              err_underflow,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int unsigned    DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = AF_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_TH[ADDR_W:0];

    logic [DATA_W-1:0] ram [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q;
    logic              valid_out_q;
    logic              wr_acc, rd_acc;

    // Flags decode only the registered count, so no input reaches them combinationally.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        count        = count_q;
        data_out     = data_out_q;
        valid_out    = valid_out_q;
    end

    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately not reset; stale words are unreachable after pointer reset.
    always_ff @(posedge clk) begin
        if (reset_L && wr_acc) begin
            ram[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_out_q <= rd_acc;
            if (rd_acc) begin
                data_out_q <= ram[rd_ptr_q];
            end
        end
    end

`ifdef FIFO_ERR_EN
    logic err_overflow_q, err_underflow_q;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            err_overflow_q  <= err_overflow_q  | (wr_en && full);
            err_underflow_q <= err_underflow_q | (rd_en && empty);
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
`endif

endmodule

// File: tb/tb_fifo_dram_param.sv
// Directed plus randomized bench for fifo_dram_param against a queue-based reference.
// Error-flag checks are compiled in when FIFO_ERR_EN is defined.
module tb_fifo_dram_param;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic [3:0] data_out;
    logic       valid_out, full, empty, almost_full, almost_empty;
    logic [3:0] count;
`ifdef FIFO_ERR_EN
    logic       err_overflow, err_underflow;
`endif

    fifo_dram_param #(
        .DATA_W (4),
        .ADDR_W (3),
        .AF_TH  (6),
        .AE_TH  (2)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
        .err_overflow (err_overflow),
        .err_underflow(err_underflow),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: a plain queue of stored words plus last popped word.
    logic [3:0] q[$];
    logic [3:0] m_dout = '0;
    bit         m_valid = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r_l, input bit w, input logic [3:0] d, input bit r);
        int n;
        n = q.size();
        if (!r_l) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            if (w && n == 8) m_ovf = 1'b1;
            if (r && n == 0) m_unf = 1'b1;
            m_valid = r && n > 0;
            if (m_valid) m_dout = q.pop_front();
            if (w && n < 8) q.push_back(d);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ".count"}, 32'(count), 32'(n));
        chk({ctx, ".empty"}, 32'(empty), 32'(n == 0));
        chk({ctx, ".full"}, 32'(full), 32'(n == 8));
        chk({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= 6));
        chk({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
        chk({ctx, ".valid_out"}, 32'(valid_out), 32'(m_valid));
        chk({ctx, ".data_out"}, 32'(data_out), 32'(m_dout));
`ifdef FIFO_ERR_EN
        chk({ctx, ".err_overflow"}, 32'(err_overflow), 32'(m_ovf));
        chk({ctx, ".err_underflow"}, 32'(err_underflow), 32'(m_unf));
`endif
    endtask

    // Drive one cycle, advance the model across the edge, sample 1 time unit later.
    task automatic cyc(input string ctx, input bit r_l, input bit w, input logic [3:0] d,
                       input bit r);
        reset_L = r_l;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        model_step(r_l, w, d, r);
        #1;
        check_all(ctx);
    endtask

    task automatic wr(input string ctx, input logic [3:0] d);
        cyc(ctx, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic rd(input string ctx);
        cyc(ctx, 1'b1, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        // 1: reset
        cyc("reset0", 1'b0, 1'b0, 4'h0, 1'b0);
        cyc("reset1", 1'b0, 1'b1, 4'h5, 1'b1);
        chk("reset.count_const", 32'(count), 32'd0);
        chk("reset.data_out_const", 32'(data_out), 32'd0);

        // 2: fill to full, then overflow attempt
        for (int i = 1; i <= 8; i++) wr("fill", 4'(i));
        chk("fill.full_const", 32'(full), 32'd1);
        wr("overflow", 4'hF);
        // 3: drain from full, then underflow attempt
        for (int i = 1; i <= 8; i++) begin
            rd("drain");
            chk("drain.order", 32'(data_out), 32'(i));
        end
        rd("underflow");
        chk("underflow.valid", 32'(valid_out), 32'd0);
        cyc("idle", 1'b1, 1'b0, 4'h0, 1'b0);

        // 4: pointer wrap
        for (int i = 0; i < 6; i++) wr("wrap.w6", 4'(i));
        for (int i = 0; i < 6; i++) rd("wrap.r6");
        for (int i = 0; i < 5; i++) wr("wrap.w5", 4'(4'hA + i));
        for (int i = 0; i < 5; i++) begin
            rd("wrap.r5");
            chk("wrap.order", 32'(data_out), 32'(4'hA + i));
        end
        chk("wrap.count_const", 32'(count), 32'd0);

        // 5: simultaneous read/write at mid, empty and full occupancy
        for (int i = 0; i < 4; i++) wr("sim.pre", 4'(i + 1));
        for (int i = 0; i < 3; i++) cyc("sim.mid", 1'b1, 1'b1, 4'(8 + i), 1'b1);
        for (int i = 0; i < 4; i++) rd("sim.drain");
        cyc("sim.empty", 1'b1, 1'b1, 4'h7, 1'b1);
        chk("sim.empty_count", 32'(count), 32'd1);
        for (int i = 0; i < 7; i++) wr("sim.fill", 4'(i));
        cyc("sim.full", 1'b1, 1'b1, 4'h9, 1'b1);
        chk("sim.full_count", 32'(count), 32'd7);

        // 6: reset mid-operation with a write pending
        cyc("rst.drain", 1'b1, 1'b0, 4'h0, 1'b0);
        while (q.size() > 5) rd("rst.trim");
        cyc("rst.mid", 1'b0, 1'b1, 4'hC, 1'b0);
        chk("rst.count_const", 32'(count), 32'd0);
        wr("rst.w3", 4'h3);
        rd("rst.r3");
        chk("rst.read3", 32'(data_out), 32'h3);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
                4'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
